// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the hazard controller: instruction codes,
// one-hot status values, the "no register" ID and the ret FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'b1000;
    localparam logic [3:0] S_HLT = 4'b0100;
    localparam logic [3:0] S_ADR = 4'b0010;
    localparam logic [3:0] S_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        IDLE,
        RET_WAIT
    } ret_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones and can be frozen by hold.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!hold && inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Y86 pipeline hazard controller: load-use, mispredict and ret handling,
// data-memory freeze with busy timeout, halt latch and saturating event counters.
module pipeline_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned RET_BUBBLES = 3,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16,
    parameter logic [3:0]  RNONE       = y86_pkg::RNONE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic             m_busy,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_stall,
    output logic             E_bubble,
    output logic             M_stall,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             setcc,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [2:0]  RET_LOAD    = 3'(RET_BUBBLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    logic       load_use;
    logic       mispredict;
    logic       ret_hit;
    logic       ret_active;
    logic       ret_start;
    logic       freeze;
    logic       unused_m_icode;

    ret_state_t state, state_nxt;
    logic [2:0] rcnt, rcnt_nxt;
    logic [15:0] busy_cnt;
    logic [15:0] busy_inc;

    // Memory-stage icode is not needed for any hazard decision here.
    assign unused_m_icode = ^M_icode;

    assign freeze     = m_busy;
    assign load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                        (E_dstM != RNONE) &&
                        ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mispredict = (E_icode == I_JXX) && !e_Cnd;
    assign ret_hit    = (D_icode == I_RET) && !load_use && !mispredict;

    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        ret_active = 1'b0;
        ret_start  = 1'b0;
        case (state)
            IDLE: begin
                if (ret_hit) begin
                    ret_active = 1'b1;
                    ret_start  = 1'b1;
                    // A single-bubble ret is fully covered by this cycle.
                    if (RET_BUBBLES > 1) begin
                        state_nxt = RET_WAIT;
                        rcnt_nxt  = RET_LOAD;
                    end
                end
            end
            RET_WAIT: begin
                ret_active = 1'b1;
                if (rcnt == 3'd1) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else if (!freeze) begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    assign busy_inc = busy_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (m_busy) begin
            if (busy_cnt != '1) begin
                busy_cnt <= busy_inc;
            end
            if (busy_inc == TIMEOUT_LIM) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            busy_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (W_stat != S_AOK) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_stall  = 1'b0;
        E_bubble = 1'b0;
        M_stall  = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_stall = 1'b1;
            end else begin
                F_stall  = load_use || ret_active;
                D_stall  = load_use;
                D_bubble = mispredict || (ret_active && !load_use);
                E_bubble = mispredict || load_use;
            end
            M_bubble = (m_stat != S_AOK) || (W_stat != S_AOK);
            // A halted pipeline stays parked regardless of freeze.
            if (halted) begin
                F_stall = 1'b1;
                W_stall = 1'b1;
            end
        end
    end

    assign setcc = (E_icode == I_OPQ) && (m_stat == S_AOK) &&
                   (W_stat == S_AOK) && !halted;

    sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_use),
        .hold  (freeze),
        .count (load_use_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mispredict),
        .hold  (freeze),
        .count (mispredict_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ret_start),
        .hold  (freeze),
        .count (ret_cnt)
    );

endmodule
